mod13_display_driver: RTL

Downstream consumer of the 4-bit mod-13 counter output. It checks that the incoming count follows a legal mod-13 sequence and produces a one-cycle wrap pulse on each 12->0 transition. It also keeps an 8-bit wrap tally and drives a 4-digit, time-multiplexed, active-low 7-segment display showing the current count (decimal) and the wrap tally (hex).

---
 rtl/mod13_pkg.sv | 26 ++
 rtl/mod13_display_driver_hex_to_seg7.sv | 11 +
 rtl/mod13_display_driver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mod13_pkg.sv
// Shared constants, segment glyph table and digit-index type for the mod-13 display driver.
// Segment bit order is {g,f,e,d,c,b,a}, active-low.
package mod13_pkg;

  localparam int MOD_DEFAULT         = 13;
  localparam int MAX_COUNT           = MOD_DEFAULT - 1;
  localparam int REFRESH_DIV_DEFAULT = 100000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ERR_E = 7'b0000110;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    DIG_ONES    = 2'd0,
    DIG_TENS    = 2'd1,
    DIG_WRAP_LO = 2'd2,
    DIG_WRAP_HI = 2'd3
  } digit_idx_t;

endpackage

// File: rtl/mod13_display_driver_hex_to_seg7.sv
// Combinational 4-bit to active-low 7-segment decoder, hex glyphs 0-F.
import mod13_pkg::*;

module hex_to_seg7 (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/mod13_display_driver.sv
// Checks an upstream mod-13 count stream, pulses on each 12->0 wrap, tallies wraps
// and multiplexes count (decimal) and tally (hex) onto a 4-digit active-low display.
import mod13_pkg::*;

module mod13_display_driver #(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT,
  parameter int MOD         = MOD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  output logic       wrap_pulse,
  output logic [7:0] wrap_count,
  output logic       err,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int              RW           = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0]   REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [4:0]      MOD_5        = 5'(MOD);
  localparam logic [3:0]      LAST_COUNT   = 4'(MOD - 1);

  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    prev_q, prev_d;
  logic          vld_q, vld_d;
  logic          first_q, first_d;
  logic          err_q, err_d;
  logic          wrap_pulse_q, wrap_pulse_d;
  logic [7:0]    wrap_count_q, wrap_count_d;
  logic [RW-1:0] refresh_q, refresh_d;
  digit_idx_t    digit_q, digit_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic       checked, step_ok, range_err, wrap_det, refresh_wrap;
  logic       cnt_oor, has_tens, blank, show_err;
  logic [3:0] ones, nibble;
  logic [6:0] dec_seg;

  // Sequence checking and wrap detection on the registered sample pair.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d     = count;
    prev_d    = cnt_q;
    vld_d     = 1'b1;
    // cnt_q becomes the baseline at the first edge where it is valid
    first_d   = first_q & ~vld_q;
    checked   = vld_q & ~first_q;
    range_err = vld_q && ({1'b0, cnt_q} >= MOD_5);
    step_ok   = (cnt_q == prev_q) ||
                (cnt_q == ((prev_q == LAST_COUNT) ? 4'd0 : prev_q + 4'd1));
    wrap_det  = checked && (prev_q == LAST_COUNT) && (cnt_q == 4'd0);

    err_d        = err_q | range_err | (checked & ~step_ok);
    wrap_pulse_d = wrap_det;
    wrap_count_d = wrap_count_q + {7'd0, wrap_det};

    refresh_wrap = (refresh_q == REFRESH_LAST);
    refresh_d    = refresh_wrap ? '0 : refresh_q + RW'(1);
    digit_d      = refresh_wrap ? digit_idx_t'(digit_q + 2'd1) : digit_q;
  end

  // Digit mux ahead of the single decoder; blanking and the error glyph override afterwards.
  always_comb begin
    cnt_oor  = ({1'b0, cnt_q} >= MOD_5);
    has_tens = !cnt_oor && (cnt_q >= 4'd10);
    ones     = has_tens ? cnt_q - 4'd10 : cnt_q;
    blank    = 1'b0;
    show_err = 1'b0;
    nibble   = ones;
    case (digit_q)
      DIG_ONES:    show_err = cnt_oor;
      DIG_TENS: begin
        nibble = 4'd1;
        blank  = !has_tens;
      end
      DIG_WRAP_LO: nibble = wrap_count_q[3:0];
      DIG_WRAP_HI: nibble = wrap_count_q[7:4];
      default:     nibble = ones;
    endcase
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex (nibble),
    .seg (dec_seg)
  );

  always_comb begin
    seg_d = dec_seg;
    an_d  = ~(4'b0001 << digit_q);
    if (blank) begin
      seg_d = SEG_BLANK;
      an_d  = 4'hF;
    end else if (show_err) begin
      seg_d = SEG_ERR_E;
    end
  end

  // NOTE: state uses non-blocking assignment only; reset is synchronous so it sits inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 4'd0;
      prev_q       <= 4'd0;
      vld_q        <= 1'b0;
      first_q      <= 1'b1;
      err_q        <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= 8'd0;
      refresh_q    <= '0;
      digit_q      <= DIG_ONES;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'hF;
    end else begin
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      vld_q        <= vld_d;
      first_q      <= first_d;
      err_q        <= err_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
      refresh_q    <= refresh_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;
  assign err        = err_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule
